// File: rtl/regdump_sequencer_pkg.sv
// Shared definitions for the register-dump debug sequencer.
package regdump_sequencer_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    STREAM  = 2'd2
  } state_t;

  // Width of the processor's debug register index (DBtheReg)
  localparam int DBG_IDXW = 4;

  // R15 reads back as the PC+8 view; the sequencer captures it unmodified
  localparam logic [DBG_IDXW-1:0] R15_IDX = 4'd15;

endpackage

// File: rtl/regdump_buffer.sv
// Snapshot buffer: NREGS x 32-bit array, one synchronous write port and
// one combinational read port. Storage is deliberately not reset.
module regdump_buffer #(
  parameter int NREGS = 16,
  parameter int IDXW  = 4
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [31:0]     wr_data,
  input  logic [IDXW-1:0] rd_idx,
  output logic [31:0]     rd_data
);

  logic [31:0] mem_r [NREGS];

  // Write the selected entry; index compare per entry keeps NREGS=1 clean
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (wr_en && (wr_idx == IDXW'(i))) begin
        mem_r[i] <= wr_data;
      end
    end
  end

  // Combinational read mux; out-of-range indices read as zero
  always_comb begin
    rd_data = 32'd0;
    for (int i = 0; i < NREGS; i++) begin
      rd_data = (rd_idx == IDXW'(i)) ? mem_r[i] : rd_data;
    end
  end

endmodule

// File: rtl/regdump_sequencer.sv
// Register-file dump sequencer: sweeps the debug read port into a snapshot
// buffer while the CPU is held, then streams the words over valid/ready.
module regdump_sequencer
  import regdump_sequencer_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int IDXW  = DBG_IDXW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [IDXW-1:0] user_sel,
  output logic [IDXW-1:0] DBtheReg,
  input  logic [31:0]     DBtheRegVal,
  output logic            cpu_hold,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic [IDXW-1:0] out_index,
  output logic            out_last,
  output logic            done
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREGS - 1);
  localparam logic [IDXW-1:0] ONE_IDX  = IDXW'(1);
  localparam logic [IDXW-1:0] ZERO_IDX = {IDXW{1'b0}};

  state_t            state_r;
  state_t            state_n;
  logic [IDXW-1:0]   idx_r;
  logic [IDXW-1:0]   idx_n;
  logic              wr_en_s;
  logic [31:0]       rd_data_s;
  logic              done_n;
  logic              out_valid_n;
  logic              out_last_n;
  logic [IDXW-1:0]   out_index_n;
  logic [31:0]       out_data_n;
  logic              cpu_hold_n;
  logic              busy_n;

  // The read port looks ahead at the next index so out_data can be registered
  regdump_buffer #(
    .NREGS (NREGS),
    .IDXW  (IDXW)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_idx  (idx_r),
    .wr_data (DBtheRegVal),
    .rd_idx  (idx_n),
    .rd_data (rd_data_s)
  );

  // Debug index mux: the counter owns the port only while capturing
  assign DBtheReg = (state_r == CAPTURE) ? idx_r : user_sel;

  // Next state, counter, buffer write and next registered outputs
  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    wr_en_s = 1'b0;
    done_n  = 1'b0;

    if (abort) begin
      state_n = IDLE;
      idx_n   = ZERO_IDX;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_n = CAPTURE;
            idx_n   = ZERO_IDX;
          end else begin
            state_n = IDLE;
          end
        end
        CAPTURE: begin
          wr_en_s = 1'b1;
          if (idx_r == LAST_IDX) begin
            state_n = STREAM;
            idx_n   = ZERO_IDX;
          end else begin
            idx_n   = idx_r + ONE_IDX;
          end
        end
        STREAM: begin
          // out_valid is always high in STREAM, so out_ready alone completes a beat
          if (out_ready) begin
            if (idx_r == LAST_IDX) begin
              state_n = IDLE;
              idx_n   = ZERO_IDX;
              done_n  = 1'b1;
            end else begin
              idx_n   = idx_r + ONE_IDX;
            end
          end else begin
            idx_n = idx_r;
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = ZERO_IDX;
        end
      endcase
    end

    cpu_hold_n  = (state_n == CAPTURE);
    busy_n      = (state_n != IDLE);
    out_valid_n = (state_n == STREAM);

    if (state_n == STREAM) begin
      out_index_n = idx_n;
      out_last_n  = (idx_n == LAST_IDX);
      // Bypass when the entry being presented is written on this same edge
      if (wr_en_s && (idx_r == idx_n)) begin
        out_data_n = DBtheRegVal;
      end else begin
        out_data_n = rd_data_s;
      end
    end else begin
      out_index_n = ZERO_IDX;
      out_last_n  = 1'b0;
      out_data_n  = 32'd0;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      idx_r     <= ZERO_IDX;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_index <= ZERO_IDX;
      out_data  <= 32'd0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_n;
      idx_r     <= idx_n;
      cpu_hold  <= cpu_hold_n;
      busy      <= busy_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
      out_index <= out_index_n;
      out_data  <= out_data_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_regdump_sequencer.sv
// Self-checking bench for regdump_sequencer (NREGS=16 and NREGS=1 builds).
module tb_regdump_sequencer;
  import regdump_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  // Main DUT (NREGS = 16)
  logic        start, abort, out_ready;
  logic [3:0]  user_sel, DBtheReg, out_index;
  logic [31:0] DBtheRegVal, out_data, base;
  logic        cpu_hold, busy, out_valid, out_last, done;

  // Regfile model: Rn = base + n
  assign DBtheRegVal = base + {28'd0, DBtheReg};

  regdump_sequencer #(.NREGS(16), .IDXW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .user_sel(user_sel),
    .DBtheReg(DBtheReg), .DBtheRegVal(DBtheRegVal), .cpu_hold(cpu_hold), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .done(done)
  );

  // Single-register DUT (NREGS = 1)
  logic        s1_start, s1_abort, s1_out_ready;
  logic [3:0]  s1_user_sel, s1_DBtheReg, s1_out_index;
  logic [31:0] s1_DBtheRegVal, s1_out_data;
  logic        s1_cpu_hold, s1_busy, s1_out_valid, s1_out_last, s1_done;

  assign s1_DBtheRegVal = 32'h5500_0000 + {28'd0, s1_DBtheReg};

  regdump_sequencer #(.NREGS(1), .IDXW(4)) dut1 (
    .clk(clk), .reset(reset), .start(s1_start), .abort(s1_abort), .user_sel(s1_user_sel),
    .DBtheReg(s1_DBtheReg), .DBtheRegVal(s1_DBtheRegVal), .cpu_hold(s1_cpu_hold),
    .busy(s1_busy), .out_valid(s1_out_valid), .out_ready(s1_out_ready),
    .out_data(s1_out_data), .out_index(s1_out_index), .out_last(s1_out_last),
    .done(s1_done)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] exp_reg;
    logic       exp_valid;
  } idle_vec_t;

  idle_vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a dump and follow it to done/abort, checking each presented word.
  // rdy_pat[cyc%4] is out_ready per cycle; abort_word aborts when that word
  // is presented; inject_start pulses start once in CAPTURE and once in STREAM.
  task automatic run_dump(input logic [3:0] rdy_pat, input int abort_word,
                          input bit inject_start,
                          output int words, output int caps, output int dones);
    int          exp_idx = 0;
    int          cyc = 0;
    bit          fin = 0;
    bit          last_acc = 0;
    bit          stalled = 0;
    bit          aborted = 0;
    logic [31:0] hold_d = 32'd0;
    logic [3:0]  hold_i = 4'd0;
    words = 0; caps = 0; dones = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (!fin && cyc < 300) begin
      if (cpu_hold) caps++;
      if (stalled) begin
        check("stall_data_stable", out_data, hold_d);
        check("stall_index_stable", {28'd0, out_index}, {28'd0, hold_i});
      end
      if (last_acc) check("done_after_last", {31'd0, done}, 32'd1);
      if (done) begin
        dones++;
        fin = 1;
      end
      if (aborted) begin
        check("abort_valid_low", {31'd0, out_valid}, 32'd0);
        check("abort_busy_low", {31'd0, busy}, 32'd0);
        fin = 1;
      end
      if (!fin) begin
        out_ready = rdy_pat[cyc % 4];
        if (inject_start && (cyc == 3 || cyc == 20)) start = 1'b1;
        last_acc = 0;
        stalled = 0;
        if (out_valid) begin
          check("word_data", out_data, base + exp_idx);
          check("word_index", {28'd0, out_index}, exp_idx);
          check("word_last", {31'd0, out_last}, (exp_idx == 15) ? 32'd1 : 32'd0);
          if (exp_idx == abort_word) begin
            abort = 1'b1;
            aborted = 1;
          end else if (out_ready) begin
            words++;
            last_acc = out_last;
            exp_idx++;
          end else begin
            stalled = 1;
            hold_d = out_data;
            hold_i = out_index;
          end
        end
        step();
        abort = 1'b0;
        start = 1'b0;
        cyc++;
      end
    end
    if (!fin) check("dump_timeout", 32'd0, 32'd1);
    // done is a single-cycle pulse, and nothing follows an abort
    step();
    check("done_cleared", {31'd0, done}, 32'd0);
    check("idle_after_dump", {31'd0, busy}, 32'd0);
    out_ready = 1'b1;
  endtask

  int w, c, d;
  int busy_seen;

  initial begin
    reset = 1'b1;
    start = 1'b0; abort = 1'b0; out_ready = 1'b1; user_sel = 4'd0;
    base = 32'hA000_0000;
    s1_start = 1'b0; s1_abort = 1'b0; s1_out_ready = 1'b1; s1_user_sel = 4'd0;

    // Idle pass-through vectors, hand-computed
    tbl[0] = '{sel: 4'd0,  exp_reg: 4'd0,  exp_valid: 1'b0};
    tbl[1] = '{sel: 4'd1,  exp_reg: 4'd1,  exp_valid: 1'b0};
    tbl[2] = '{sel: 4'd5,  exp_reg: 4'd5,  exp_valid: 1'b0};
    tbl[3] = '{sel: 4'd7,  exp_reg: 4'd7,  exp_valid: 1'b0};
    tbl[4] = '{sel: 4'd10, exp_reg: 4'd10, exp_valid: 1'b0};
    tbl[5] = '{sel: 4'd12, exp_reg: 4'd12, exp_valid: 1'b0};
    tbl[6] = '{sel: R15_IDX, exp_reg: 4'd15, exp_valid: 1'b0};
    tbl[7] = '{sel: 4'd3,  exp_reg: 4'd3,  exp_valid: 1'b0};

    // Reset state
    #12;
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_out_index", {28'd0, out_index}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_s1_valid", {31'd0, s1_out_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Idle: DBtheReg follows user_sel combinationally
    for (int i = 0; i < 8; i++) begin
      user_sel = tbl[i].sel;
      #1;
      check("idle_dbthereg", {28'd0, DBtheReg}, {28'd0, tbl[i].exp_reg});
      check("idle_valid", {31'd0, out_valid}, {31'd0, tbl[i].exp_valid});
      step();
    end
    // Combinational sweep of all indices without waiting for a clock edge
    for (int i = 0; i < 16; i++) begin
      user_sel = 4'(i);
      #1;
      check("idle_sweep", {28'd0, DBtheReg}, i);
    end
    step();

    // Full dump, out_ready held high
    run_dump(4'b1111, -1, 1'b0, w, c, d);
    check("t1_words", w, 16);
    check("t1_capture_cycles", c, 16);
    check("t1_done_count", d, 1);

    // Back-pressure 1,0,0,1,...
    base = 32'hA000_0000;
    run_dump(4'b1001, -1, 1'b0, w, c, d);
    check("t2_words", w, 16);
    check("t2_capture_cycles", c, 16);
    check("t2_done_count", d, 1);

    // Abort while the 5th word (index 4) is presented
    run_dump(4'b1111, 4, 1'b0, w, c, d);
    check("t3_words_before_abort", w, 4);
    check("t3_no_done", d, 0);

    // Fresh dump after abort, with new register contents
    base = 32'hB000_0000;
    run_dump(4'b1111, -1, 1'b0, w, c, d);
    check("t3b_words", w, 16);
    check("t3b_done_count", d, 1);

    // start while busy is ignored and not queued
    base = 32'hA000_0000;
    run_dump(4'b1111, -1, 1'b1, w, c, d);
    check("t4_words", w, 16);
    check("t4_capture_cycles", c, 16);
    check("t4_done_count", d, 1);
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_seen++;
      step();
    end
    check("t4_no_queued_dump", busy_seen, 0);

    // Asynchronous reset in the middle of CAPTURE
    user_sel = 4'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("t5_capturing", {31'd0, cpu_hold}, 32'd1);
    check("t5_capture_index", {28'd0, DBtheReg}, 32'd4);
    #3;
    reset = 1'b1;
    #1;
    check("t5_rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_idle_sel", {28'd0, DBtheReg}, 32'd9);
    @(negedge clk);
    reset = 1'b0;
    step();

    // NREGS = 1 build
    s1_start = 1'b1;
    step();
    s1_start = 1'b0;
    check("s1_capture_hold", {31'd0, s1_cpu_hold}, 32'd1);
    check("s1_capture_valid", {31'd0, s1_out_valid}, 32'd0);
    step();
    check("s1_hold_dropped", {31'd0, s1_cpu_hold}, 32'd0);
    check("s1_valid", {31'd0, s1_out_valid}, 32'd1);
    check("s1_data", s1_out_data, 32'h5500_0000);
    check("s1_index", {28'd0, s1_out_index}, 32'd0);
    check("s1_last", {31'd0, s1_out_last}, 32'd1);
    step();
    check("s1_done", {31'd0, s1_done}, 32'd1);
    check("s1_valid_after", {31'd0, s1_out_valid}, 32'd0);
    step();
    check("s1_done_pulse", {31'd0, s1_done}, 32'd0);
    check("s1_idle", {31'd0, s1_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regdump_sequencer.md
Name: regdump_sequencer

Overview:
- Debug consumer attached to the processor's register-file debug port (DBtheReg / DBtheRegVal).
- On a start pulse, it sweeps DBtheReg through registers 0..NREGS-1, one per cycle, and captures each value into a local snapshot buffer.
- It then streams the captured words out over a valid/ready handshake to the board-level debug link.
- While idle, it passes a user-selected register index straight through, so switch-driven inspection keeps working.

Parameters:
- NREGS, 16, number of registers captured (1..16), starting at R0.
- IDXW, 4, register index width (matches the DBtheReg width).

Ports:
- clk  in  1  rising-edge clock, same as the processor.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a dump; honoured only in IDLE.
- abort  in  1  forces a return to IDLE on the next edge; the buffer contents are kept.
- user_sel  in  4  register index driven onto DBtheReg while IDLE.
- DBtheReg  out  4  debug read index to the processor's register file.
- DBtheRegVal  in  32  combinational debug read data from the register file.
- cpu_hold  out  1  high during CAPTURE; top level uses it to freeze PC and regfile writes.
- busy  out  1  high in CAPTURE or STREAM.
- out_valid  out  1  stream word valid.
- out_ready  in  1  consumer ready.
- out_data  out  32  captured register value.
- out_index  out  4  register number of out_data.
- out_last  out  1  high with the final word (index NREGS-1).
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- States: IDLE, CAPTURE, STREAM.
- Internal state: a registered IDXW-bit counter idx and a buffer buf[0..NREGS-1] of 32-bit words.
- Reset (asynchronous) values: state=IDLE, idx=0, cpu_hold=0, busy=0, out_valid=0, out_last=0, done=0, out_index=0, out_data=0.
- Buffer contents are not reset. Nothing in the block reads them before they are written.
- IDLE:
  - DBtheReg = user_sel, combinationally.
  - start=1 -> CAPTURE with idx=0.
- CAPTURE:
  - DBtheReg = idx, driven from the register.
  - Each cycle, buf[idx] <= DBtheRegVal, sampled at the edge.
  - idx increments each cycle. When idx==NREGS-1 -> STREAM with idx=0.
  - Exactly NREGS cycles; cpu_hold=1 throughout.
- STREAM:
  - out_valid=1, out_data=buf[idx], out_index=idx, out_last=(idx==NREGS-1).
  - DBtheReg = user_sel.
  - On out_valid & out_ready: idx++. If out_last, go to IDLE and pulse done for 1 cycle.
  - out_data, out_index and out_last stay stable while out_valid=1 and out_ready=0.
- Timing: start sampled at edge k -> CAPTURE occupies the cycles after edges k..k+NREGS-1 -> out_valid first high after edge k+NREGS.
- start while busy is ignored, with no queuing.
- abort has priority over start and handshake. From any state -> IDLE, idx=0. No done pulse. cpu_hold drops on the next edge.
- start and abort in the same IDLE cycle: stay in IDLE.
- NREGS=1: a single CAPTURE cycle; the one stream word has out_last=1.
- A register read of R15 returns the processor's PC+8 view. It is captured as-is, with no correction.
- out_valid, out_last, cpu_hold, busy and done are all decoded from registered state. No combinational path exists from out_ready to out_valid.

Decomposition:
- Shared debug package holds:
  - state encoding constants IDLE=2'd0, CAPTURE=2'd1, STREAM=2'd2;
  - the debug index width (4);
  - the R15 index constant.
- One natural sub-module: regdump_buffer, an NREGS x 32 write-port/read-port register array (write enable, write index, read index). The FSM and counter stay in the top level.

Test Plan:
- Regfile model with Rn = 32'hA000_0000+n, out_ready held at 1; pulse start -> cpu_hold high exactly 16 cycles, then 16 words 32'hA000_0000..32'hA000_000F with out_index 0..15, out_last only on index 15, done one cycle after.
- Same setup, out_ready toggling 1,0,0,1,... -> no word dropped or duplicated, and out_data/out_index stay stable while stalled; total accepted = 16.
- Assert abort at the 5th STREAM word -> out_valid low the next cycle, no done pulse. A new start then produces a full, fresh 16-word dump.
- Pulse start during CAPTURE and during STREAM -> ignored: a single 16-word dump only, and the capture count stays 16.
- In IDLE, sweep user_sel 0..15 -> DBtheReg follows user_sel in the same cycle. Assert reset mid-CAPTURE -> cpu_hold, busy and out_valid go to 0 immediately (asynchronous), state is IDLE.
- NREGS=1 build, start -> 1 capture cycle, one word with index 0 and out_last=1, then done.
